vga_sprite_engine: RTL and testbench

Parametrised successor to the single-ball VGA peripheral. It is an Avalon memory-mapped slave that generates 640x480 VGA timing from the 50 MHz system clock and composites NUM_BALLS square sprites over a programmable background. Position and colour writes go to shadow registers and are committed at the end of each frame (tear-free), with an optional vertical-blank interrupt. It sits between the HPS lightweight bridge and the board VGA DAC.

---
 rtl/vga_sprite_engine.sv | 259 +++++++++++++++++++++++++
 tb/tb_vga_sprite_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_engine.sv
// rtl/vga_sprite_engine.sv - Avalon-MM VGA sprite compositor
// Shadow registers are committed to the active set at the end of the visible frame.
module vga_sprite_engine #(
  parameter int NUM_BALLS    = 4,
  parameter int BALL_LOG2    = 4,
  parameter int ADDR_W       = 5,
  parameter int H_ACTIVE     = 1280,
  parameter int H_SYNC_START = 1312,
  parameter int H_SYNC_END   = 1504,
  parameter int H_TOTAL      = 1600,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int V_TOTAL      = 525
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_n,
  output logic              VGA_SYNC_n
);

  localparam int BALL_SIZE = 1 << BALL_LOG2;

  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        line_end;
  logic        commit;

  assign line_end = (hcount == 11'(H_TOTAL - 1));
  assign commit   = line_end && (vcount == 10'(V_ACTIVE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (line_end) begin
      hcount <= '0;
      vcount <= (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  logic                 wr_en;
  logic                 rd_en;
  logic                 sel_bg;
  logic                 sel_ctrl;
  logic [NUM_BALLS-1:0] sel_pos;
  logic [NUM_BALLS-1:0] sel_attr;

  assign wr_en    = chipselect & write;
  assign rd_en    = chipselect & read;
  assign sel_bg   = (address == ADDR_W'(0));
  assign sel_ctrl = (address == ADDR_W'(1));

  always_comb begin
    sel_pos  = '0;
    sel_attr = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      sel_pos[i]  = (address == ADDR_W'(2 + 2 * i));
      sel_attr[i] = (address == ADDR_W'(3 + 2 * i));
    end
  end

  logic        irq_en;
  logic        vblank_pending;
  logic        immediate;
  logic [23:0] bg_sh;
  logic [23:0] bg_act;

  // Frame-end set takes priority over a coincident write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en         <= 1'b0;
      vblank_pending <= 1'b0;
      immediate      <= 1'b0;
    end else begin
      if (wr_en && sel_ctrl) begin
        irq_en    <= writedata[0];
        immediate <= writedata[2];
      end
      if (commit && irq_en)
        vblank_pending <= 1'b1;
      else if (wr_en && sel_ctrl && writedata[1])
        vblank_pending <= 1'b0;
    end
  end

  assign irq = vblank_pending & irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bg_sh  <= 24'h000080;
      bg_act <= 24'h000080;
    end else begin
      if (wr_en && sel_bg)
        bg_sh <= writedata[23:0];
      if (commit)
        bg_act <= bg_sh;
      else if (immediate && wr_en && sel_bg)
        bg_act <= writedata[23:0];
    end
  end

  logic [9:0]  pos_x_sh  [NUM_BALLS];
  logic [9:0]  pos_y_sh  [NUM_BALLS];
  logic [23:0] rgb_sh    [NUM_BALLS];
  logic        en_sh     [NUM_BALLS];
  logic [9:0]  pos_x_act [NUM_BALLS];
  logic [9:0]  pos_y_act [NUM_BALLS];
  logic [23:0] rgb_act   [NUM_BALLS];
  logic        en_act    [NUM_BALLS];

  // A write landing on the commit edge only reaches the shadow copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        pos_x_sh[i]  <= '0;
        pos_y_sh[i]  <= '0;
        rgb_sh[i]    <= 24'hFFFFFF;
        en_sh[i]     <= 1'b0;
        pos_x_act[i] <= '0;
        pos_y_act[i] <= '0;
        rgb_act[i]   <= 24'hFFFFFF;
        en_act[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        if (wr_en && sel_pos[i]) begin
          pos_x_sh[i] <= writedata[9:0];
          pos_y_sh[i] <= writedata[25:16];
        end
        if (wr_en && sel_attr[i]) begin
          rgb_sh[i] <= writedata[23:0];
          en_sh[i]  <= writedata[24];
        end
        if (commit) begin
          pos_x_act[i] <= pos_x_sh[i];
          pos_y_act[i] <= pos_y_sh[i];
          rgb_act[i]   <= rgb_sh[i];
          en_act[i]    <= en_sh[i];
        end else if (immediate && wr_en) begin
          if (sel_pos[i]) begin
            pos_x_act[i] <= writedata[9:0];
            pos_y_act[i] <= writedata[25:16];
          end
          if (sel_attr[i]) begin
            rgb_act[i] <= writedata[23:0];
            en_act[i]  <= writedata[24];
          end
        end
      end
    end
  end

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (sel_bg)
      rd_mux = {8'h00, bg_sh};
    if (sel_ctrl)
      rd_mux = {29'd0, immediate, vblank_pending, irq_en};
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (sel_pos[i])
        rd_mux = {6'd0, pos_y_sh[i], 6'd0, pos_x_sh[i]};
      if (sel_attr[i])
        rd_mux = {7'd0, en_sh[i], rgb_sh[i]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata <= '0;
    else if (rd_en)
      readdata <= rd_mux;
  end

  logic [9:0]           col;
  logic [9:0]           row;
  logic [NUM_BALLS-1:0] ball_hit;
  logic [23:0]          hit_rgb;
  logic [23:0]          pixel_rgb;
  logic                 active_video;
  logic                 hs_n;
  logic                 vs_n;

  assign col = hcount[10:1];
  assign row = vcount;

  // One extra bit on the bounds keeps x+size from wrapping, so sprites clip at the edge.
  always_comb begin
    ball_hit = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      ball_hit[i] = en_act[i]
        && ({1'b0, col} >= {1'b0, pos_x_act[i]})
        && ({1'b0, col} <  {1'b0, pos_x_act[i]} + 11'(BALL_SIZE))
        && ({1'b0, row} >= {1'b0, pos_y_act[i]})
        && ({1'b0, row} <  {1'b0, pos_y_act[i]} + 11'(BALL_SIZE));
    end
  end

  always_comb begin
    hit_rgb = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (ball_hit[i])
        hit_rgb = rgb_act[i];
    end
  end

  assign active_video = (hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
  assign hs_n = !((hcount >= 11'(H_SYNC_START)) && (hcount < 11'(H_SYNC_END)));
  assign vs_n = !((vcount >= 10'(V_SYNC_START)) && (vcount < 10'(V_SYNC_END)));

  always_comb begin
    pixel_rgb = '0;
    if (active_video)
      pixel_rgb = (|ball_hit) ? hit_rgb : bg_act;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_n <= 1'b0;
      VGA_CLK     <= 1'b0;
    end else begin
      VGA_R       <= pixel_rgb[23:16];
      VGA_G       <= pixel_rgb[15:8];
      VGA_B       <= pixel_rgb[7:0];
      VGA_HS      <= hs_n;
      VGA_VS      <= vs_n;
      VGA_BLANK_n <= active_video;
      VGA_CLK     <= hcount[0];
    end
  end

  assign VGA_SYNC_n = 1'b0;

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:26];

endmodule

// File: tb/tb_vga_sprite_engine.sv
// tb/tb_vga_sprite_engine.sv - directed bench for vga_sprite_engine
// Uses a shrunken raster (same structure as 640x480) so several frames fit in a short run.
module tb_vga_sprite_engine;

  localparam int HA = 96, HSS = 100, HSE = 108, HT = 112;
  localparam int VA = 40, VSS = 42, VSE = 44, VT = 45;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] BG0 = 24'h000080, RED = 24'hFF0000;
  localparam logic [23:0] GRN = 24'h00FF00, YEL = 24'hFFFF00, BLK = 24'h000000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [4:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

  int n_checks = 0;
  int n_fail = 0;

  vga_sprite_engine #(
    .NUM_BALLS(4), .BALL_LOG2(4), .ADDR_W(5),
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata), .irq(irq),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n)
  );

  always #5 clk = ~clk;

  // Reference raster position: (mh,mv) is the current state, (ph,pv) the state the outputs show.
  int mh, mv, ph, pv;
  bit pvalid;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mh <= 0; mv <= 0; ph <= 0; pv <= 0; pvalid <= 1'b0;
    end else begin
      ph <= mh; pv <= mv; pvalid <= 1'b1;
      if (mh == HT - 1) begin
        mh <= 0;
        mv <= (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh <= mh + 1;
      end
    end
  end

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  // Returns the colour shown for counter state (h,v); X if it never appears in the budget.
  task automatic wait_hv(input int h, input int v, output logic [23:0] rgb);
    bit found = 1'b0;
    rgb = 'x;
    for (int k = 0; k < 2 * FRAME + HT && !found; k++) begin
      @(negedge clk);
      if (pvalid && ph == h && pv == v) begin
        rgb = {VGA_R, VGA_G, VGA_B};
        found = 1'b1;
      end
    end
  endtask

  task automatic wait_commit(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2 * FRAME && !ok; k++) begin
      @(negedge clk);
      if (mh == HT - 1 && mv == VA - 1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [12:0] got, exp;
    repeat (3) @(negedge clk);
    got = {VGA_R, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_CLK};
    exp = {8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_r_sync got %h want %h", got, exp); end
    n_checks++;
    if ({VGA_G, VGA_B} !== 16'h0) begin n_fail++; $display("FAIL reset_gb got %h want 0", {VGA_G, VGA_B}); end
    n_checks++;
    if ({readdata, irq, VGA_SYNC_n} !== 34'h0) begin
      n_fail++; $display("FAIL reset_rd_irq got %h/%b/%b want 0", readdata, irq, VGA_SYNC_n);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== BG0) begin
      n_fail++; $display("FAIL first_pixel got %h want %h", {VGA_R, VGA_G, VGA_B}, BG0);
    end
    n_checks++;
    if ({VGA_BLANK_n, VGA_HS, VGA_VS, VGA_CLK} !== 4'b1110) begin
      n_fail++; $display("FAIL first_sync got %b want 1110", {VGA_BLANK_n, VGA_HS, VGA_VS, VGA_CLK});
    end
  endtask

  task automatic test_regs;
    logic [31:0] d;
    logic [4:0]  addrs [7] = '{5'd0, 5'd1, 5'd2, 5'd5, 5'd3, 5'd10, 5'd31};
    logic [31:0] exps  [7] = '{32'h80, 32'h0, 32'h0, 32'h00FFFFFF, 32'h01123456, 32'h0, 32'h0};
    bus_write(5'd3, 32'h01123456);
    bus_write(5'd10, 32'hDEADBEEF);
    bus_write(5'd31, 32'hCAFEF00D);
    for (int i = 0; i < 7; i++) begin
      bus_read(addrs[i], d);
      n_checks++;
      if (d !== exps[i]) begin n_fail++; $display("FAIL read_addr%0d got %h want %h", addrs[i], d, exps[i]); end
    end
    @(negedge clk);
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL readdata_hold got %h want 0", readdata); end
  endtask

  task automatic test_sync;
    int hs_low = 0, clk_hi = 0, vs_low = 0, vis = 0;
    for (int k = 0; k < HT; k++) begin
      @(negedge clk);
      if (VGA_HS === 1'b0) hs_low++;
      if (VGA_CLK === 1'b1) clk_hi++;
    end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (VGA_VS === 1'b0) vs_low++;
      if (VGA_BLANK_n === 1'b1) vis++;
    end
    n_checks++;
    if (hs_low != HSE - HSS) begin n_fail++; $display("FAIL hs_low got %0d want %0d", hs_low, HSE - HSS); end
    n_checks++;
    if (clk_hi != HT / 2) begin n_fail++; $display("FAIL vga_clk_high got %0d want %0d", clk_hi, HT / 2); end
    n_checks++;
    if (vs_low != 2 * HT) begin n_fail++; $display("FAIL vs_low got %0d want %0d", vs_low, 2 * HT); end
    n_checks++;
    if (vis != HA * VA) begin n_fail++; $display("FAIL blank_n_high got %0d want %0d", vis, HA * VA); end
  endtask

  task automatic test_commit;
    logic [23:0] rgb;
    int          hs   [6] = '{40, 38, 40, 70, 72, 70};
    int          vs   [6] = '{9, 10, 10, 25, 25, 26};
    logic [23:0] exps [6] = '{BG0, BG0, RED, RED, BG0, BG0};
    wait_hv(0, 0, rgb);
    bus_write(5'd2, (32'd10 << 16) | 32'd20);
    bus_write(5'd3, 32'h01FF0000);
    wait_hv(42, 12, rgb);
    n_checks++;
    if (rgb !== BG0) begin n_fail++; $display("FAIL precommit got %h want %h", rgb, BG0); end
    for (int i = 0; i < 6; i++) begin
      wait_hv(hs[i], vs[i], rgb);
      n_checks++;
      if (rgb !== exps[i]) begin
        n_fail++; $display("FAIL commit_col%0d_row%0d got %h want %h", hs[i] / 2, vs[i], rgb, exps[i]);
      end
    end
  endtask

  task automatic test_priority;
    logic [23:0] rgb;
    bus_write(5'd4, (32'd20 << 16) | 32'd28);
    bus_write(5'd5, 32'h0100FF00);
    wait_hv(0, 0, rgb);
    wait_hv(60, 22, rgb);
    n_checks++;
    if (rgb !== RED) begin n_fail++; $display("FAIL overlap got %h want %h", rgb, RED); end
    wait_hv(80, 30, rgb);
    n_checks++;
    if (rgb !== GRN) begin n_fail++; $display("FAIL sprite1_only got %h want %h", rgb, GRN); end
    bus_write(5'd3, 32'h00FF0000);
    wait_hv(0, 0, rgb);
    wait_hv(50, 15, rgb);
    n_checks++;
    if (rgb !== BG0) begin n_fail++; $display("FAIL sprite0_disabled got %h want %h", rgb, BG0); end
    wait_hv(60, 22, rgb);
    n_checks++;
    if (rgb !== GRN) begin n_fail++; $display("FAIL overlap_after_disable got %h want %h", rgb, GRN); end
  endtask

  task automatic test_clip;
    logic [23:0] rgb;
    int          hs   [6] = '{80, 88, 0, 94, 100, 88};
    int          vs   [6] = '{0, 32, 33, 39, 39, 40};
    logic [23:0] exps [6] = '{BG0, YEL, BG0, YEL, BLK, BLK};
    bus_write(5'd6, (32'd32 << 16) | 32'd40);
    bus_write(5'd7, 32'h01FFFF00);
    wait_hv(0, 0, rgb);
    for (int i = 0; i < 6; i++) begin
      wait_hv(hs[i], vs[i], rgb);
      n_checks++;
      if (rgb !== exps[i]) begin
        n_fail++; $display("FAIL clip_h%0d_v%0d got %h want %h", hs[i], vs[i], rgb, exps[i]);
      end
    end
  endtask

  task automatic test_irq;
    bit ok;
    logic [31:0] d;
    bus_write(5'd1, 32'h1);
    wait_commit(ok);
    n_checks++;
    if ({ok, irq} !== 2'b10) begin n_fail++; $display("FAIL irq_before_commit got ok=%b irq=%b want ok=1 irq=0", ok, irq); end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise got %b want 1", irq); end
    bus_read(5'd1, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL ctrl_read got %h want 3", d); end
    bus_write(5'd1, 32'h3);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_w1c got %b want 0", irq); end
    wait_commit(ok);
    bus_write(5'd1, 32'h3);
    n_checks++;
    if ({ok, irq} !== 2'b11) begin n_fail++; $display("FAIL irq_set_beats_w1c got ok=%b irq=%b want 1/1", ok, irq); end
  endtask

  task automatic test_immediate;
    logic [23:0] rgb;
    logic [31:0] d;
    wait_hv(0, 0, rgb);
    bus_write(5'd1, 32'h5);
    bus_write(5'd0, 32'h00112233);
    wait_hv(20, 5, rgb);
    n_checks++;
    if (rgb !== 24'h112233) begin n_fail++; $display("FAIL immediate_bg got %h want 112233", rgb); end
    bus_read(5'd0, d);
    n_checks++;
    if (d !== 32'h00112233) begin n_fail++; $display("FAIL bg_read got %h want 00112233", d); end
  endtask

  task automatic test_reset_midline;
    logic [31:0] d;
    logic [23:0] rgb;
    n_checks++;
    if ({irq, VGA_BLANK_n} !== 2'b11) begin n_fail++; $display("FAIL pre_reset_state got %b want 11", {irq, VGA_BLANK_n}); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== BLK) begin n_fail++; $display("FAIL async_rgb got %h want 0", {VGA_R, VGA_G, VGA_B}); end
    n_checks++;
    if ({VGA_HS, VGA_VS, VGA_BLANK_n, VGA_CLK, irq} !== 5'b11000) begin
      n_fail++; $display("FAIL async_ctl got %b want 11000", {VGA_HS, VGA_VS, VGA_BLANK_n, VGA_CLK, irq});
    end
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL async_readdata got %h want 0", readdata); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rgb = {VGA_R, VGA_G, VGA_B};
    n_checks++;
    if (rgb !== BG0) begin n_fail++; $display("FAIL restart_pixel got %h want %h", rgb, BG0); end
    bus_read(5'd1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_after_reset got %h want 0", d); end
    bus_read(5'd7, d);
    n_checks++;
    if (d !== 32'h00FFFFFF) begin n_fail++; $display("FAIL attr2_after_reset got %h want 00FFFFFF", d); end
  endtask

  initial begin
    test_reset;
    test_regs;
    test_sync;
    test_commit;
    test_priority;
    test_clip;
    test_irq;
    test_immediate;
    test_reset_midline;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
